fifo_rr_arbiter: RTL and testbench

- Round-robin read scheduler that drains up to num_fifos upstream FIFOs into one downstream FIFO of the transmission layer.
- Generates rd_enable toward each upstream FIFO and wr_enable toward the downstream FIFO, with backpressure from the downstream almost_full_fifo.
- Holds and distributes the almost-full/almost-empty threshold configuration to the FIFOs.
- Sequences FIFO start-up and aggregates FIFO error flags.

---
 rtl/fifo_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler: drains several upstream FIFOs into one downstream
// FIFO, distributes threshold configuration and aggregates error flags.
module fifo_rr_arbiter #(
  parameter int unsigned data_width    = 6,
  parameter int unsigned address_width = 2,
  parameter int unsigned num_fifos     = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init,
  input  logic [address_width-1:0]        umbral_af_in,
  input  logic [address_width-1:0]        umbral_ae_in,
  input  logic [num_fifos-1:0]            empty_in,
  input  logic [num_fifos-1:0]            error_in,
  input  logic [num_fifos*data_width-1:0] data_in,
  input  logic                            almost_full_out,
  output logic [num_fifos-1:0]            pop_out,
  output logic                            push_out,
  output logic [data_width-1:0]           data_out,
  output logic [address_width-1:0]        umbral_af,
  output logic [address_width-1:0]        umbral_ae,
  output logic [1:0]                      state,
  output logic                            idle_out,
  output logic                            error_out
);

  localparam int unsigned IdxW = (num_fifos > 1) ? $clog2(num_fifos) : 1;

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StInit   = 2'd1,
    StIdle   = 2'd2,
    StActive = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [IdxW-1:0]         sel_q, sel_d;
  logic [IdxW-1:0]         gnt_idx;
  logic                    gnt_found;
  logic [num_fifos-1:0]    pop_q, pop_d;
  logic                    vld_q, vld_d;
  logic                    push_q, push_d;
  logic [data_width-1:0]   data_q, data_d;
  logic [data_width-1:0]   slice;
  logic [address_width-1:0] af_q, af_d, ae_q, ae_d;
  logic                    err_q, err_d;
  logic                    in_flight;

  // A word is in flight from its pop cycle until the cycle before its push.
  assign in_flight = (|pop_q) | vld_q;

  // Round-robin search: first non-empty FIFO after the pointer, wrapping around.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int unsigned k = 1; k <= num_fifos; k++) begin
      if (!gnt_found && !empty_in[ptr_q + IdxW'(k)]) begin
        gnt_idx   = ptr_q + IdxW'(k);
        gnt_found = 1'b1;
      end
    end
  end

  // FSM next state, grant decision and threshold loading.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pop_d   = '0;
    af_d    = af_q;
    ae_d    = ae_q;
    if (init) begin
      af_d = umbral_af_in;
      ae_d = umbral_ae_in;
    end
    case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        if (!init) state_d = StIdle;
      end
      StIdle: begin
        if (init) begin
          state_d = StInit;
        end else if (!(&empty_in) && !almost_full_out) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (init) begin
          state_d = StInit;
        end else begin
          if (!almost_full_out && gnt_found) begin
            pop_d[gnt_idx] = 1'b1;
            ptr_d          = gnt_idx;
          end
          if ((&empty_in) && !in_flight) state_d = StIdle;
        end
      end
      default: state_d = StReset;
    endcase
  end

  // Read-data pipeline: remember which FIFO was popped, capture its word next cycle.
  always_comb begin
    sel_d = '0;
    for (int unsigned i = 0; i < num_fifos; i++) begin
      if (pop_q[i]) sel_d = IdxW'(i);
    end
    slice = '0;
    for (int unsigned i = 0; i < num_fifos; i++) begin
      if (sel_q == IdxW'(i)) slice = data_in[i*data_width +: data_width];
    end
    vld_d  = |pop_q;
    push_d = vld_q;
    data_d = vld_q ? slice : data_q;
    err_d  = err_q | (|error_in);
  end

  // State registers; pointer resets to the last FIFO so FIFO 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReset;
      ptr_q   <= IdxW'(num_fifos - 1);
      sel_q   <= '0;
      pop_q   <= '0;
      vld_q   <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
      af_q    <= '0;
      ae_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      pop_q   <= pop_d;
      vld_q   <= vld_d;
      push_q  <= push_d;
      data_q  <= data_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      err_q   <= err_d;
    end
  end

  assign pop_out   = pop_q;
  assign push_out  = push_q;
  assign data_out  = data_q;
  assign umbral_af = af_q;
  assign umbral_ae = ae_q;
  assign state     = state_q;
  assign idle_out  = (state_q == StIdle) && !in_flight;
  assign error_out = err_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with behavioural upstream FIFOs and a
// push scoreboard keyed on expected data and arrival cycle.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [1:0]  umbral_af_in, umbral_ae_in;
  logic [3:0]  empty_in, error_in;
  logic [23:0] data_in;
  logic        almost_full_out;
  logic [3:0]  pop_out;
  logic        push_out;
  logic [5:0]  data_out;
  logic [1:0]  umbral_af, umbral_ae;
  logic [1:0]  state;
  logic        idle_out, error_out;

  fifo_rr_arbiter #(
    .data_width   (6),
    .address_width(2),
    .num_fifos    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .umbral_af_in   (umbral_af_in),
    .umbral_ae_in   (umbral_ae_in),
    .empty_in       (empty_in),
    .error_in       (error_in),
    .data_in        (data_in),
    .almost_full_out(almost_full_out),
    .pop_out        (pop_out),
    .push_out       (push_out),
    .data_out       (data_out),
    .umbral_af      (umbral_af),
    .umbral_ae      (umbral_ae),
    .state          (state),
    .idle_out       (idle_out),
    .error_out      (error_out)
  );

  always #5 clk = ~clk;

  // Upstream FIFO models: word appears on data_out the cycle after rd_enable.
  // empty already accounts for the read in progress.
  logic [5:0] mem [4][32];
  int         loaded [4];
  int         popped [4];
  logic [5:0] dout   [4];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) popped[i] <= loaded[i];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop_out[i] && popped[i] < 32) begin
          dout[i]   <= mem[i][popped[i]];
          popped[i] <= popped[i] + 1;
        end
      end
    end
  end

  always_comb begin
    empty_in = '0;
    for (int i = 0; i < 4; i++) begin
      empty_in[i] = (loaded[i] - popped[i]) <= (pop_out[i] ? 1 : 0);
    end
  end

  assign data_in = {dout[3], dout[2], dout[1], dout[0]};

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         push_cnt = 0;
  int         last_push = -1;
  int         last_grant = -1;
  int         exp_pop[$];
  logic [5:0] sb_data[$];
  int         sb_due[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic load(input int f, input logic [5:0] w);
    mem[f][loaded[f]] = w;
    loaded[f] = loaded[f] + 1;
  endtask

  // Compare observed pops and pushes against the expectation queues.
  task automatic monitor();
    int         idx;
    int         e;
    logic [5:0] w;
    if (pop_out != 4'b0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (pop_out[i]) idx = i;
      check("pop_onehot", 32'($onehot(pop_out)), 32'd1);
      if (exp_pop.size() == 0) begin
        check("pop_unexpected", 32'(pop_out), 32'd0);
      end else begin
        e = exp_pop.pop_front();
        check("pop_index", 32'(idx), 32'(e));
      end
      sb_data.push_back((popped[idx] < 32) ? mem[idx][popped[idx]] : 6'h0);
      sb_due.push_back(cyc + 2);
      last_grant = idx;
    end
    if (push_out) begin
      push_cnt++;
      last_push = cyc;
      if (sb_data.size() == 0) begin
        check("push_unexpected", 32'(push_out), 32'd0);
      end else begin
        w = sb_data.pop_front();
        e = sb_due.pop_front();
        check("push_data", 32'(data_out), 32'(w));
        check("push_cycle", 32'(cyc), 32'(e));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  // Run until the expected stream has fully drained, bounded by a cycle budget.
  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (idle_out && exp_pop.size() == 0 && sb_data.size() == 0) break;
    end
    check("drain_idle", 32'(idle_out), 32'd1);
    check("drain_state", 32'(state), 32'd2);
    check("drain_idle_cycle", 32'(cyc), 32'(last_push + 1));
    check("drain_pops_left", 32'(exp_pop.size()), 32'd0);
    check("drain_pushes_left", 32'(sb_data.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    init = 1'b0;
    umbral_af_in = 2'd0;
    umbral_ae_in = 2'd0;
    error_in = 4'b0;
    almost_full_out = 1'b0;

    // Reset and start-up
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pop", 32'(pop_out), 32'd0);
    check("rst_push", 32'(push_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_af", 32'(umbral_af), 32'd0);
    check("rst_ae", 32'(umbral_ae), 32'd0);
    check("rst_idle", 32'(idle_out), 32'd0);
    check("rst_err", 32'(error_out), 32'd0);
    tick();
    reset = 1'b1;
    init = 1'b1;
    umbral_af_in = 2'd2;
    umbral_ae_in = 2'd1;
    tick();
    check("init_state", 32'(state), 32'd1);
    check("init_af", 32'(umbral_af), 32'd2);
    check("init_ae", 32'(umbral_ae), 32'd1);
    check("init_pop", 32'(pop_out), 32'd0);
    init = 1'b0;
    tick();
    check("idle_state", 32'(state), 32'd2);
    check("idle_flag", 32'(idle_out), 32'd1);
    check("idle_pop", 32'(pop_out), 32'd0);

    // Fairness across all four FIFOs
    for (int i = 0; i < 4; i++) load(i, 6'(8'h10 + i));
    for (int i = 0; i < 4; i++) load(i, 6'(8'h20 + i));
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) exp_pop.push_back(i);
    run_until_idle(60);

    // Skip empty FIFOs 0 and 2
    load(1, 6'h05);
    load(1, 6'h06);
    load(3, 6'h07);
    load(3, 6'h08);
    exp_pop = {1, 3, 1, 3};
    run_until_idle(60);

    // Backpressure mid-stream
    for (int i = 0; i < 4; i++) load(i, 6'(8'h30 + i));
    for (int i = 0; i < 4; i++) load(i, 6'(8'h34 + i));
    exp_pop = {0, 1, 2};
    repeat (4) tick();
    check("bp_last_grant", 32'(last_grant), 32'd2);
    almost_full_out = 1'b1;
    push_cnt = 0;
    repeat (6) begin
      tick();
      check("bp_no_pop", 32'(pop_out), 32'd0);
    end
    check("bp_inflight_pushes", 32'(push_cnt), 32'd2);
    check("bp_state", 32'(state), 32'd3);
    exp_pop = {3, 0, 1, 2, 3};
    almost_full_out = 1'b0;
    run_until_idle(60);

    // Reconfigure mid-stream, then error pulse
    for (int i = 0; i < 4; i++) load(i, 6'(8'h08 + i));
    for (int i = 0; i < 4; i++) load(i, 6'(8'h0C + i));
    exp_pop = {0, 1, 2};
    repeat (4) tick();
    init = 1'b1;
    umbral_af_in = 2'd3;
    umbral_ae_in = 2'd2;
    push_cnt = 0;
    tick();
    check("cfg_state", 32'(state), 32'd1);
    check("cfg_af", 32'(umbral_af), 32'd3);
    check("cfg_ae", 32'(umbral_ae), 32'd2);
    check("cfg_pop", 32'(pop_out), 32'd0);
    repeat (3) tick();
    check("cfg_pending_pushes", 32'(push_cnt), 32'd2);
    check("cfg_sb_empty", 32'(sb_data.size()), 32'd0);
    check("cfg_no_pop", 32'(pop_out), 32'd0);
    check("err_before", 32'(error_out), 32'd0);
    error_in = 4'b0100;
    tick();
    error_in = 4'b0000;
    check("err_set", 32'(error_out), 32'd1);
    repeat (3) tick();
    check("err_sticky", 32'(error_out), 32'd1);
    check("cfg_hold_state", 32'(state), 32'd1);
    exp_pop = {3, 0, 1, 2, 3};
    init = 1'b0;
    run_until_idle(60);
    check("err_sticky_end", 32'(error_out), 32'd1);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 4; i++) load(i, 6'(8'h2A + i));
    exp_pop = {0, 1, 2, 3};
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_pop", 32'(pop_out), 32'd0);
    check("mid_rst_push", 32'(push_out), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_af", 32'(umbral_af), 32'd0);
    check("mid_rst_ae", 32'(umbral_ae), 32'd0);
    check("mid_rst_err", 32'(error_out), 32'd0);
    exp_pop.delete();
    sb_data.delete();
    sb_due.delete();
    tick();
    reset = 1'b1;
    init = 1'b1;
    umbral_af_in = 2'd1;
    umbral_ae_in = 2'd0;
    tick();
    check("rerun_state", 32'(state), 32'd1);
    check("rerun_af", 32'(umbral_af), 32'd1);
    check("rerun_ae", 32'(umbral_ae), 32'd0);
    init = 1'b0;
    tick();
    check("rerun_idle", 32'(state), 32'd2);
    // Pointer must be back at the top: FIFO 0 wins over FIFO 2
    load(2, 6'h3A);
    load(0, 6'h3B);
    exp_pop = {0, 2};
    run_until_idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
